// File: rtl/mem_map_pkg.sv
// Shared memory-map constants and boot state encoding for the memory responder.
package mem_map_pkg;

    // Boot/run sequencing of the memory port.
    typedef enum logic [1:0] {
        StLoad  = 2'd0,
        StFlush = 2'd1,
        StRun   = 2'd2
    } boot_state_e;

    // Upper 24 address bits that select the MMIO page.
    localparam logic [23:0] MMIO_TAG = 24'hFFFFFF;

    localparam logic [31:0] LED_ADDR    = 32'hFFFF_FF00;
    localparam logic [31:0] TIMER_ADDR  = 32'hFFFF_FF04;
    localparam logic [31:0] STATUS_ADDR = 32'hFFFF_FF08;

    // True when a byte address falls on the given MMIO register word.
    function automatic logic mmio_match(input logic [31:0] addr, input logic [31:0] reg_addr);
        return (addr[31:8] == MMIO_TAG) && (addr[7:2] == reg_addr[7:2]);
    endfunction

endpackage

// File: rtl/boot_ram.sv
// Word-addressed RAM: one synchronous write port, one asynchronous read port.
module boot_ram #(
    parameter int unsigned ADDR_W = 10
) (
    input  logic              CLK,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [31:0]       wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [31:0]       rdata
);

    logic [31:0] mem [2**ADDR_W];

    // Contents are deliberately not reset so a reboot keeps unwritten words.
    always_ff @(posedge CLK) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: boot loader, RAM front end, and MMIO page (LED, timer, status).
module mem_responder
    import mem_map_pkg::*;
#(
    parameter int unsigned ADDR_W  = 10,
    parameter int unsigned TIMER_W = 32
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_reset,
    input  logic        load_valid,
    input  logic [7:0]  load_byte,
    input  logic        load_last,
    output logic        load_ready,
    output logic [7:0]  led,
    output logic        bad_addr
);

    boot_state_e       state_q, state_d;
    logic [ADDR_W-1:0] load_ptr_q, load_ptr_d;
    logic [1:0]        byte_cnt_q, byte_cnt_d;
    // Upper three bytes of the word being packed; unfilled bytes stay zero.
    logic [23:0]       part_q, part_d;
    logic [7:0]        led_q, led_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic              bad_q, bad_d;

    logic              ram_we;
    logic [ADDR_W-1:0] ram_waddr;
    logic [31:0]       ram_wdata;
    logic [31:0]       ram_rdata;
    logic [ADDR_W-1:0] ram_idx;

    logic              run;
    logic              ram_hit;
    logic              led_hit;
    logic              timer_hit;
    logic              status_hit;
    logic              unmapped;
    logic [31:0]       timer_ext;

    // Word access only; the byte offset is intentionally ignored.
    logic unused_byte_offset;
    assign unused_byte_offset = ^cpu_addr[1:0];

    assign run        = (state_q == StRun);
    assign ram_idx    = cpu_addr[ADDR_W+1:2];
    assign ram_hit    = (cpu_addr[31:ADDR_W+2] == '0);
    assign led_hit    = mmio_match(cpu_addr, LED_ADDR);
    assign timer_hit  = mmio_match(cpu_addr, TIMER_ADDR);
    assign status_hit = mmio_match(cpu_addr, STATUS_ADDR);
    assign unmapped   = !(ram_hit || led_hit || timer_hit || status_hit);

    assign cpu_reset  = !run;
    assign load_ready = (state_q == StLoad);
    assign led        = led_q;
    assign bad_addr   = bad_q;

    boot_ram #(
        .ADDR_W (ADDR_W)
    ) u_boot_ram (
        .CLK   (CLK),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .raddr (ram_idx),
        .rdata (ram_rdata)
    );

    // Loader FSM next state and RAM write-port mux (loader owns it until RUN).
    always_comb begin
        state_d    = state_q;
        load_ptr_d = load_ptr_q;
        byte_cnt_d = byte_cnt_q;
        part_d     = part_q;
        ram_we     = 1'b0;
        ram_waddr  = load_ptr_q;
        ram_wdata  = {part_q, 8'h00};

        unique case (state_q)
            StLoad: begin
                if (load_valid) begin
                    if (byte_cnt_q == 2'd3) begin
                        ram_we     = 1'b1;
                        ram_wdata  = {part_q, load_byte};
                        load_ptr_d = load_ptr_q + ADDR_W'(1);
                        byte_cnt_d = 2'd0;
                        part_d     = '0;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 2'd1;
                        unique case (byte_cnt_q)
                            2'd0:    part_d[23:16] = load_byte;
                            2'd1:    part_d[15:8]  = load_byte;
                            default: part_d[7:0]   = load_byte;
                        endcase
                    end
                    if (load_last) begin
                        state_d = StFlush;
                    end
                end
            end
            StFlush: begin
                ram_we     = (byte_cnt_q != 2'd0);
                byte_cnt_d = 2'd0;
                part_d     = '0;
                state_d    = StRun;
            end
            StRun: begin
                ram_we    = MemWrite && ram_hit;
                ram_waddr = ram_idx;
                ram_wdata = cpu_wdata;
            end
            default: begin
                state_d = StLoad;
            end
        endcase
    end

    // MMIO register updates; the timer only runs, and a clear beats the increment.
    always_comb begin
        led_d   = led_q;
        timer_d = '0;
        bad_d   = bad_q;
        if (run) begin
            timer_d = timer_q + TIMER_W'(1);
            if (MemWrite && timer_hit) begin
                timer_d = '0;
            end
            if (MemWrite && led_hit) begin
                led_d = cpu_wdata[7:0];
            end
            if ((MemRead || MemWrite) && unmapped) begin
                bad_d = 1'b1;
            end
        end
    end

    // Zero-extend the timer onto the 32-bit read bus.
    always_comb begin
        timer_ext                = '0;
        timer_ext[TIMER_W-1:0]   = timer_q;
    end

    // Combinational read mux; pre-write data is returned on a same-cycle read/write.
    always_comb begin
        cpu_rdata = '0;
        if (run && MemRead) begin
            if (ram_hit) begin
                cpu_rdata = ram_rdata;
            end else if (led_hit) begin
                cpu_rdata = {24'h0, led_q};
            end else if (timer_hit) begin
                cpu_rdata = timer_ext;
            end else if (status_hit) begin
                cpu_rdata = 32'h0000_0001;
            end
        end
    end

    // State registers with synchronous reset; RAM contents are not touched here.
    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q    <= StLoad;
            load_ptr_q <= '0;
            byte_cnt_q <= 2'd0;
            part_q     <= '0;
            led_q      <= 8'h00;
            timer_q    <= '0;
            bad_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            load_ptr_q <= load_ptr_d;
            byte_cnt_q <= byte_cnt_d;
            part_q     <= part_d;
            led_q      <= led_d;
            timer_q    <= timer_d;
            bad_q      <= bad_d;
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder with a per-cycle reference model and literal checks.
module tb_mem_responder;

    localparam int DEPTH = 1024;

    logic        CLK = 1'b0;
    logic        reset = 1'b1;
    logic        MemRead = 1'b0;
    logic        MemWrite = 1'b0;
    logic [31:0] cpu_addr = '0;
    logic [31:0] cpu_wdata = '0;
    logic [31:0] cpu_rdata;
    logic        cpu_reset;
    logic        load_valid = 1'b0;
    logic [7:0]  load_byte = '0;
    logic        load_last = 1'b0;
    logic        load_ready;
    logic [7:0]  led;
    logic        bad_addr;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en = 1'b0;

    mem_responder dut (
        .CLK        (CLK),
        .reset      (reset),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_rdata  (cpu_rdata),
        .cpu_reset  (cpu_reset),
        .load_valid (load_valid),
        .load_byte  (load_byte),
        .load_last  (load_last),
        .load_ready (load_ready),
        .led        (led),
        .bad_addr   (bad_addr)
    );

    always #5 CLK = ~CLK;

    // Reference model: phase 0 = loading, 1 = flushing, 2 = running.
    logic [31:0] m_mem [DEPTH];
    bit          m_known [DEPTH];
    int          m_phase = 0;
    logic [7:0]  m_bytes [$];
    int          m_ptr = 0;
    logic [7:0]  m_led = '0;
    logic [31:0] m_timer = '0;
    bit          m_bad = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_pack();
        logic [31:0] w = '0;
        for (int i = 0; i < m_bytes.size(); i++) begin
            w = w | ({24'h0, m_bytes[i]} << (24 - 8 * i));
        end
        return w;
    endfunction

    function automatic bit is_unmapped(input logic [31:0] a);
        logic [31:0] w = {a[31:2], 2'b00};
        return !(a < 32'h1000 || w == 32'hFFFF_FF00 || w == 32'hFFFF_FF04
                 || w == 32'hFFFF_FF08);
    endfunction

    always @(posedge CLK) begin
        if (reset) begin
            m_phase = 0;
            m_bytes.delete();
            m_ptr   = 0;
            m_led   = '0;
            m_timer = '0;
            m_bad   = 1'b0;
        end else if (m_phase == 0) begin
            if (load_valid) begin
                m_bytes.push_back(load_byte);
                if (m_bytes.size() == 4) begin
                    m_mem[m_ptr]   = model_pack();
                    m_known[m_ptr] = 1'b1;
                    m_ptr          = (m_ptr + 1) % DEPTH;
                    m_bytes.delete();
                end
                if (load_last) m_phase = 1;
            end
        end else if (m_phase == 1) begin
            if (m_bytes.size() != 0) begin
                m_mem[m_ptr]   = model_pack();
                m_known[m_ptr] = 1'b1;
            end
            m_bytes.delete();
            m_phase = 2;
        end else begin
            logic [31:0] wa;
            wa = {cpu_addr[31:2], 2'b00};
            m_timer = m_timer + 32'd1;
            if (MemWrite) begin
                if (cpu_addr < 32'h1000) begin
                    m_mem[cpu_addr[11:2]]   = cpu_wdata;
                    m_known[cpu_addr[11:2]] = 1'b1;
                end else if (wa == 32'hFFFF_FF00) begin
                    m_led = cpu_wdata[7:0];
                end else if (wa == 32'hFFFF_FF04) begin
                    m_timer = '0;
                end
            end
            if ((MemRead || MemWrite) && is_unmapped(cpu_addr)) m_bad = 1'b1;
        end
    end

    // Compare process: every cycle, away from the active edge.
    always @(negedge CLK) begin
        if (chk_en) begin
            logic [31:0] exp_rd;
            bit          known;
            logic [31:0] wa;
            wa     = {cpu_addr[31:2], 2'b00};
            exp_rd = '0;
            known  = 1'b1;
            if (m_phase == 2 && MemRead) begin
                if (cpu_addr < 32'h1000) begin
                    known  = m_known[cpu_addr[11:2]];
                    exp_rd = m_mem[cpu_addr[11:2]];
                end else if (wa == 32'hFFFF_FF00) exp_rd = {24'h0, m_led};
                else if (wa == 32'hFFFF_FF04) exp_rd = m_timer;
                else if (wa == 32'hFFFF_FF08) exp_rd = 32'd1;
            end
            if (known) check("model_rdata", cpu_rdata, exp_rd);
            check("model_cpu_reset", 32'(cpu_reset), 32'(m_phase != 2));
            check("model_load_ready", 32'(load_ready), 32'(m_phase == 0));
            check("model_led", 32'(led), 32'(m_led));
            check("model_bad_addr", 32'(bad_addr), 32'(m_bad));
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic last);
        load_valid = 1'b1;
        load_byte  = b;
        load_last  = last;
        tick();
        load_valid = 1'b0;
        load_last  = 1'b0;
    endtask

    task automatic cpu_write(input logic [31:0] a, input logic [31:0] d);
        MemWrite  = 1'b1;
        cpu_addr  = a;
        cpu_wdata = d;
        tick();
        MemWrite  = 1'b0;
    endtask

    task automatic cpu_read_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
        MemRead  = 1'b1;
        cpu_addr = a;
        #2;
        check(name, cpu_rdata, exp);
        tick();
        MemRead = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  boot1 [8];
        logic [15:0] wv;
        boot1 = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};

        reset = 1'b1;
        tick();
        tick();
        reset  = 1'b0;
        chk_en = 1'b1;

        // Reset values; reads are blocked while loading.
        check("rst_cpu_reset", 32'(cpu_reset), 32'd1);
        check("rst_load_ready", 32'(load_ready), 32'd1);
        check("rst_led", 32'(led), 32'd0);
        check("rst_bad_addr", 32'(bad_addr), 32'd0);
        MemRead  = 1'b1;
        cpu_addr = 32'h0;
        #2;
        check("load_rdata_zero", cpu_rdata, 32'h0);
        MemRead = 1'b0;

        // Boot two words.
        for (int i = 0; i < 8; i++) send_byte(boot1[i], (i == 7));
        check("flush_cpu_reset", 32'(cpu_reset), 32'd1);
        check("flush_load_ready", 32'(load_ready), 32'd0);
        tick();
        check("run_cpu_reset", 32'(cpu_reset), 32'd0);
        cpu_read_chk("boot_ram0", 32'h0, 32'h1234_5678);
        cpu_read_chk("boot_ram1", 32'h4, 32'h9ABC_DEF0);

        // Loader input ignored once running.
        load_valid = 1'b1;
        load_byte  = 8'h55;
        load_last  = 1'b1;
        repeat (3) tick();
        load_valid = 1'b0;
        load_last  = 1'b0;
        cpu_read_chk("run_ignores_loader", 32'h0, 32'h1234_5678);

        // MMIO.
        cpu_write(32'hFFFF_FF00, 32'h0000_00A5);
        check("led_out", 32'(led), 32'hA5);
        cpu_read_chk("led_read", 32'hFFFF_FF00, 32'h0000_00A5);
        cpu_read_chk("status_read", 32'hFFFF_FF08, 32'h1);
        cpu_write(32'hFFFF_FF08, 32'h0);
        cpu_read_chk("status_ro", 32'hFFFF_FF08, 32'h1);
        cpu_write(32'hFFFF_FF04, 32'h1234);
        repeat (3) tick();
        cpu_read_chk("timer_3", 32'hFFFF_FF04, 32'd3);

        // Same-cycle read and write returns the old value.
        cpu_write(32'h10, 32'h1111_1111);
        MemRead   = 1'b1;
        MemWrite  = 1'b1;
        cpu_addr  = 32'h10;
        cpu_wdata = 32'hDEAD_BEEF;
        #2;
        check("rw_old", cpu_rdata, 32'h1111_1111);
        tick();
        MemWrite = 1'b0;
        #2;
        check("rw_new", cpu_rdata, 32'hDEAD_BEEF);
        tick();
        MemRead = 1'b0;

        // Unmapped access, sticky error, and MemRead low.
        check("bad_before", 32'(bad_addr), 32'd0);
        cpu_read_chk("unmapped_read", 32'h8000_0000, 32'h0);
        check("bad_set", 32'(bad_addr), 32'd1);
        cpu_write(32'hFFFF_FF0C, 32'hFFFF_FFFF);
        repeat (3) tick();
        check("bad_sticky", 32'(bad_addr), 32'd1);
        cpu_addr = 32'h0;
        #2;
        check("no_read_zero", cpu_rdata, 32'h0);

        // Reset mid-run with LED and timer populated.
        cpu_write(32'hFFFF_FF00, 32'h0000_005A);
        cpu_write(32'hFFFF_FF04, 32'h0);
        repeat (100) tick();
        cpu_read_chk("timer_100", 32'hFFFF_FF04, 32'd100);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rr_led", 32'(led), 32'd0);
        check("rr_cpu_reset", 32'(cpu_reset), 32'd1);
        check("rr_load_ready", 32'(load_ready), 32'd1);
        check("rr_bad_addr", 32'(bad_addr), 32'd0);

        // Partial last word with an idle gap between bytes.
        send_byte(8'hAA, 1'b0);
        tick();
        send_byte(8'hBB, 1'b1);
        check("pf_flush_cpu_reset", 32'(cpu_reset), 32'd1);
        tick();
        check("pf_run_cpu_reset", 32'(cpu_reset), 32'd0);
        cpu_read_chk("pf_timer_zero", 32'hFFFF_FF04, 32'd0);
        cpu_read_chk("pf_ram0", 32'h0, 32'hAABB_0000);
        cpu_read_chk("pf_ram1_kept", 32'h4, 32'h9ABC_DEF0);

        // Load pointer wrap: 1025 words, the last lands back on word 0.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int w = 0; w <= DEPTH; w++) begin
            wv = w[15:0];
            send_byte(wv[15:8], 1'b0);
            send_byte(wv[7:0], 1'b0);
            send_byte(~wv[15:8], 1'b0);
            send_byte(~wv[7:0], (w == DEPTH));
        end
        tick();
        check("wrap_run", 32'(cpu_reset), 32'd0);
        cpu_read_chk("wrap_ram0", 32'h0, 32'h0400_FBFF);
        cpu_read_chk("wrap_ram1", 32'h4, 32'h0001_FFFE);
        cpu_read_chk("wrap_ram_last", 32'hFFC, 32'h03FF_FC00);

        tick();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
